ama_riscv_issue_ctrl: RTL and testbench
=======================================

# ama_riscv_issue_ctrl

Issue/interlock controller between decode and execute. Each cycle it checks the operand use of the instruction in decode against a 3-entry scoreboard of in-flight writers (EX, MEM, WB). From that check it raises a load-use style stall or produces registered forwarding selects for the operand muxes in EX. It also keeps a saturating count of interlock stall cycles for performance monitoring.

## Interface
- `CNT_W`, default 32: width of the stall performance counter.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid` in 1: decode holds a valid instruction.
- `decoded` in `decoder_t`: decoder output. Fields used:
  - `has_reg.rs1`, `has_reg.rs2`, `has_reg_p`
  - `rd_we`
  - `itype.load`, `itype.mult`
  - `csr_ctrl.en`
- `dec_rs1`, `dec_rs2`, `dec_rd` in `rf_addr_t`: register addresses of the decode instruction.
- `be_stall` in 1: backend freeze (dmem/mult not ready). The whole pipeline holds.
- `flush_ex` in 1: squash the decode instruction (taken branch/jalr redirect).
- `stall_dec` out 1: hold fetch and decode, insert a bubble into EX. Combinational.
- `fwd_a`, `fwd_b`, `fwd_p` out `fwd_sel_t`: operand sources for rs1, rs2 and paired rd-as-source, used by the instruction currently in EX. Registered.
- `stall_cnt` out `CNT_W`: interlock stall cycles.

## Operation
- **Scoreboard entries.** EX, MEM and WB each hold `{v, rd, late}`.
- **Late writers.** `late = itype.load | itype.mult | csr_ctrl.en`. Their results exist only at the end of MEM.
- **Early writers.** All other writers (ALU, unpk, jal/jalr, lui, auipc) have results at the end of EX.
- **Entry creation.** An entry is created only if `dec_valid & rd_we`; `rd_we` is already 0 for x0. x0 never matches.
- **Sources checked.**
  - rs1 if `has_reg.rs1`.
  - rs2 if `has_reg.rs2`.
  - `dec_rd` if `has_reg_p` (unpk reads rd as a third source).
- **Hazard.** Any checked source equal to `EX.rd` with `EX.v & EX.late` gives `stall_dec = dec_valid & !flush_ex`.
- **Forward select for the next cycle, per source.** The youngest match wins:
  - EX match, non-late: `FWD_MEM`.
  - Otherwise MEM match (late or not): `FWD_WB`.
  - Otherwise: `FWD_NONE`.
- **WB-stage matches.** No forward is needed; the register file is write-first.
- **Advance rule.** If `!be_stall`, then WB <= MEM and MEM <= EX.
  - EX <= decode entry if `dec_valid & !stall_dec & !flush_ex`.
  - Otherwise EX <= bubble (`v=0`), with `fwd_*` <= `FWD_NONE` for the bubble.
- **Freeze.** When `be_stall` is high, the scoreboard, `fwd_*` and the counter all hold. `stall_dec` is still computed but is not counted.
- **Counter.**
  - Increments when `stall_dec & !be_stall`.
  - Saturates at all-ones; no wrap.
- **Simultaneous stall and flush.** `flush_ex` and hazard together: flush wins, `stall_dec = 0`, bubble inserted.
- **Reset.**
  - All entries have `v = 0`.
  - `fwd_a`, `fwd_b`, `fwd_p` = `FWD_NONE`.
  - `stall_cnt` = 0.
  - `stall_dec` = 0, because the scoreboard is empty.
  - Reset mid-stream drops all in-flight tracking in the same edge.

## Timing
- **`stall_dec`.** Same-cycle combinational path from decode inputs and scoreboard flops. No path from `be_stall` into `stall_dec`.
- **Forwarding.** `fwd_*` are valid one cycle after the consumer was in decode, i.e. while it sits in EX.
- **Load-use penalty.** Exactly 1 bubble. The consumer then receives `FWD_WB`.
- **Early producer.** Back-to-back with an early producer needs no stall; the consumer receives `FWD_MEM`.
- **`stall_cnt`.** Updates on the clock edge after the counted cycle.

## Structure
- **Shared package (`ama_riscv_defines.svh`):**
  - `fwd_sel_t` (2 bits): `FWD_NONE=0`, `FWD_MEM=1`, `FWD_WB=2`; 3 reserved.
  - `sb_entry_t {v, rd, late}`.
- **Sub-module:** `ama_riscv_fwd_match`, one per source, purely combinational.
  - Inputs: source address, source-used flag, EX/MEM entries.
  - Outputs: `hazard`, `fwd_sel_t`.
- **Top:** scoreboard shift, bubble/flush muxing and the counter live in the top module.

## Test plan
- **Load-use.** `lw x5` then `add x6,x5,x1` back-to-back:
  - `stall_dec = 1` for one cycle; EX gets a bubble.
  - Add reaches EX with `fwd_a = FWD_WB`.
  - `stall_cnt = 1`.
- **Early producer chain.** `add x5` then `sub x7,x1,x5`:
  - No stall.
  - `fwd_b = FWD_MEM` in the cycle sub is in EX.
- **Youngest wins; x0 ignored.**
  - `addi x5`, `addi x5`, `or x8,x5,x5` gives `fwd_a = fwd_b = FWD_MEM`, from the younger writer.
  - `addi x0` followed by a reader of x0 gives `FWD_NONE`.
- **Paired source and CSR.**
  - `csrrs x9` then unpk with `rd = x9, has_reg_p = 1` gives a 1-cycle stall, then `fwd_p = FWD_WB`.
  - Unpk with `has_reg_p = 0` and the same addresses gives no stall.
- **Flush and freeze.**
  - Hazard coincident with `flush_ex = 1`: `stall_dec = 0`, EX bubble, counter unchanged.
  - 3 cycles of `be_stall` during a load-use: scoreboard, `fwd_*` and `stall_cnt` hold, and the stall resolves after release.
- **Reset and saturation.**
  - Assert `rst` with 3 valid entries in flight: next cycle all `fwd_* = FWD_NONE`, `stall_cnt = 0`, and a dependent instruction sees no stall.
  - With `CNT_W = 4`, 20 stall cycles give `stall_cnt = 15`.

Source files
------------

// File: rtl/ama_riscv_issue_ctrl_pkg.sv
// Shared types for the issue/interlock controller:
// decoder bundle, forward selects and scoreboard entries.
package ama_riscv_issue_ctrl_pkg;

    typedef logic [4:0] rf_addr_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } has_reg_t;

    typedef struct packed {
        logic load;
        logic mult;
    } itype_t;

    typedef struct packed {
        logic en;
    } csr_ctrl_t;

    typedef struct packed {
        has_reg_t  has_reg;
        logic      has_reg_p;
        logic      rd_we;
        itype_t    itype;
        csr_ctrl_t csr_ctrl;
    } decoder_t;

    typedef struct packed {
        logic     v;
        rf_addr_t rd;
        logic     late;
    } sb_entry_t;

    // Results of these writers only exist at the end of MEM
    function automatic logic is_late(decoder_t d);
        return d.itype.load | d.itype.mult | d.csr_ctrl.en;
    endfunction

endpackage

// File: rtl/ama_riscv_issue_ctrl_if.sv
// Decode-side bundle: instruction in decode towards the controller,
// stall and EX operand forward selects back.
interface ama_riscv_issue_ctrl_if;
    import ama_riscv_issue_ctrl_pkg::*;

    logic     dec_valid;
    decoder_t decoded;
    rf_addr_t dec_rs1;
    rf_addr_t dec_rs2;
    rf_addr_t dec_rd;
    logic     stall_dec;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    fwd_sel_t fwd_p;

    modport master (
        output dec_valid, decoded, dec_rs1, dec_rs2, dec_rd,
        input  stall_dec, fwd_a, fwd_b, fwd_p
    );

    modport slave (
        input  dec_valid, decoded, dec_rs1, dec_rs2, dec_rd,
        output stall_dec, fwd_a, fwd_b, fwd_p
    );

endinterface

// File: rtl/ama_riscv_fwd_match.sv
// Per-source scoreboard lookup: late-writer hazard in EX and the
// forward select the source needs once it reaches EX.
module ama_riscv_fwd_match
    import ama_riscv_issue_ctrl_pkg::*;
(
    input  rf_addr_t  src,
    input  logic      used,
    input  sb_entry_t ex,
    input  sb_entry_t mem,
    output logic      hazard,
    output fwd_sel_t  sel
);

    logic live;
    logic ex_hit;
    logic mem_hit;

    assign live    = used & (src != '0);
    assign ex_hit  = live & ex.v & (ex.rd == src);
    assign mem_hit = live & mem.v & (mem.rd == src);
    assign hazard  = ex_hit & ex.late;

    always_comb begin
        sel = FWD_NONE;
        if (ex_hit && !ex.late) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ama_riscv_issue_ctrl.sv
// Issue/interlock controller: scoreboard shift, load-use stall,
// registered forward selects and a saturating stall counter.
module ama_riscv_issue_ctrl
    import ama_riscv_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ama_riscv_issue_ctrl_if.slave ic,
    input  logic                  be_stall,
    input  logic                  flush_ex,
    output logic [CNT_W-1:0]      stall_cnt
);

    // WB needs no entry: the register file is write-first
    sb_entry_t ex_q;
    sb_entry_t mem_q;
    sb_entry_t dec_entry;
    fwd_sel_t  fwd_a_q, fwd_b_q, fwd_p_q;
    fwd_sel_t  sel_a, sel_b, sel_p;
    logic      hz_a, hz_b, hz_p;
    logic      stall;
    logic      issue;

    ama_riscv_fwd_match u_match_a (
        .src    (ic.dec_rs1),
        .used   (ic.decoded.has_reg.rs1),
        .ex     (ex_q),
        .mem    (mem_q),
        .hazard (hz_a),
        .sel    (sel_a)
    );

    ama_riscv_fwd_match u_match_b (
        .src    (ic.dec_rs2),
        .used   (ic.decoded.has_reg.rs2),
        .ex     (ex_q),
        .mem    (mem_q),
        .hazard (hz_b),
        .sel    (sel_b)
    );

    ama_riscv_fwd_match u_match_p (
        .src    (ic.dec_rd),
        .used   (ic.decoded.has_reg_p),
        .ex     (ex_q),
        .mem    (mem_q),
        .hazard (hz_p),
        .sel    (sel_p)
    );

    assign stall = ic.dec_valid & ~flush_ex & (hz_a | hz_b | hz_p);
    assign issue = ic.dec_valid & ~stall & ~flush_ex;

    assign dec_entry.v    = issue & ic.decoded.rd_we;
    assign dec_entry.rd   = ic.dec_rd;
    assign dec_entry.late = is_late(ic.decoded);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            fwd_a_q   <= FWD_NONE;
            fwd_b_q   <= FWD_NONE;
            fwd_p_q   <= FWD_NONE;
            stall_cnt <= '0;
        end else if (!be_stall) begin
            mem_q   <= ex_q;
            ex_q    <= dec_entry;
            fwd_a_q <= issue ? sel_a : FWD_NONE;
            fwd_b_q <= issue ? sel_b : FWD_NONE;
            fwd_p_q <= issue ? sel_p : FWD_NONE;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign ic.stall_dec = stall;
    assign ic.fwd_a     = fwd_a_q;
    assign ic.fwd_b     = fwd_b_q;
    assign ic.fwd_p     = fwd_p_q;

endmodule

// File: tb/tb_ama_riscv_issue_ctrl.sv
// Bench for the issue controller: directed pipeline scenarios with
// literal expectations plus random traffic against a history model.
module tb_ama_riscv_issue_ctrl;
    import ama_riscv_issue_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          be_stall;
    logic          flush_ex;
    logic [CW-1:0] stall_cnt;

    ama_riscv_issue_ctrl_if bus ();

    ama_riscv_issue_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ic        (bus.slave),
        .be_stall  (be_stall),
        .flush_ex  (flush_ex),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Issued-instruction history, youngest first (bubbles included)
    typedef struct {
        bit v;
        int rd;
        bit late;
    } rec_t;

    rec_t     hist[$];
    fwd_sel_t e_a, e_b, e_p;
    int       e_cnt;
    bit       started = 0;

    function automatic bit src_blocked(rf_addr_t s, logic u);
        if (!u || s == 0 || hist.size() == 0) return 0;
        return hist[0].v && hist[0].late && (hist[0].rd == int'(s));
    endfunction

    function automatic bit m_stall();
        decoder_t d;
        d = bus.decoded;
        if (!bus.dec_valid || flush_ex) return 0;
        return src_blocked(bus.dec_rs1, d.has_reg.rs1)
            || src_blocked(bus.dec_rs2, d.has_reg.rs2)
            || src_blocked(bus.dec_rd, d.has_reg_p);
    endfunction

    // Youngest producer within the last two issue slots decides
    function automatic fwd_sel_t m_fwd(rf_addr_t s, logic u);
        if (!u || s == 0) return FWD_NONE;
        for (int i = 0; i < 2 && i < hist.size(); i++) begin
            if (hist[i].v && hist[i].rd == int'(s)) begin
                if (i == 1) return FWD_WB;
                return hist[i].late ? FWD_NONE : FWD_MEM;
            end
        end
        return FWD_NONE;
    endfunction

    always @(posedge clk) begin
        bit       st;
        bit       iss;
        rec_t     r;
        decoder_t d;
        d = bus.decoded;
        if (rst) begin
            hist.delete();
            e_a = FWD_NONE;
            e_b = FWD_NONE;
            e_p = FWD_NONE;
            e_cnt = 0;
            started = 1;
        end else if (started && !be_stall) begin
            st  = m_stall();
            iss = bus.dec_valid && !st && !flush_ex;
            e_a = iss ? m_fwd(bus.dec_rs1, d.has_reg.rs1) : FWD_NONE;
            e_b = iss ? m_fwd(bus.dec_rs2, d.has_reg.rs2) : FWD_NONE;
            e_p = iss ? m_fwd(bus.dec_rd, d.has_reg_p) : FWD_NONE;
            if (st && e_cnt < CMAX) e_cnt++;
            r.v    = iss && d.rd_we;
            r.rd   = int'(bus.dec_rd);
            r.late = d.itype.load || d.itype.mult || d.csr_ctrl.en;
            hist.push_front(r);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("m_stall", 32'(bus.stall_dec), 32'(m_stall()));
            chk("m_fwd_a", 32'(bus.fwd_a), 32'(e_a));
            chk("m_fwd_b", 32'(bus.fwd_b), 32'(e_b));
            chk("m_fwd_p", 32'(bus.fwd_p), 32'(e_p));
            chk("m_cnt", 32'(stall_cnt), 32'(e_cnt));
        end
    end

    task automatic ins(bit v, int rs1, int rs2, int rd,
                       bit u1, bit u2, bit up, bit we,
                       bit ld, bit ml, bit cs);
        decoder_t d;
        d = '0;
        d.has_reg.rs1  = u1;
        d.has_reg.rs2  = u2;
        d.has_reg_p    = up;
        d.rd_we        = we;
        d.itype.load   = ld;
        d.itype.mult   = ml;
        d.csr_ctrl.en  = cs;
        bus.decoded    = d;
        bus.dec_valid  = v;
        bus.dec_rs1    = rf_addr_t'(rs1);
        bus.dec_rs2    = rf_addr_t'(rs2);
        bus.dec_rd     = rf_addr_t'(rd);
    endtask

    task automatic nop();
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic ng();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        be_stall = 0;
        flush_ex = 0;
        nop();
        tk();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        be_stall = 0;
        flush_ex = 0;
        nop();
        tk();
        tk();
        rst = 0;
        ng();
        chk("rst_stall", 32'(bus.stall_dec), 0);
        chk("rst_fwd_a", 32'(bus.fwd_a), 32'(FWD_NONE));
        chk("rst_cnt", 32'(stall_cnt), 0);
        tk();

        // load-use: lw x5 ; add x6,x5,x1
        do_reset();
        ins(1, 0, 0, 5, 1, 0, 0, 1, 1, 0, 0);
        ng(); chk("lu_first", 32'(bus.stall_dec), 0); tk();
        ins(1, 5, 1, 6, 1, 1, 0, 1, 0, 0, 0);
        ng(); chk("lu_stall", 32'(bus.stall_dec), 1); tk();
        ng(); chk("lu_release", 32'(bus.stall_dec), 0); tk();
        nop();
        ng();
        chk("lu_fwd_a", 32'(bus.fwd_a), 32'(FWD_WB));
        chk("lu_fwd_b", 32'(bus.fwd_b), 32'(FWD_NONE));
        chk("lu_cnt", 32'(stall_cnt), 1);
        tk();

        // early producer: add x5 ; sub x7,x1,x5
        do_reset();
        ins(1, 1, 2, 5, 1, 1, 0, 1, 0, 0, 0); tk();
        ins(1, 1, 5, 7, 1, 1, 0, 1, 0, 0, 0);
        ng(); chk("ep_stall", 32'(bus.stall_dec), 0); tk();
        nop();
        ng(); chk("ep_fwd_b", 32'(bus.fwd_b), 32'(FWD_MEM)); tk();

        // youngest wins, then x0 ignored
        do_reset();
        ins(1, 1, 0, 5, 1, 0, 0, 1, 0, 0, 0); tk();
        ins(1, 2, 0, 5, 1, 0, 0, 1, 0, 0, 0); tk();
        ins(1, 5, 5, 8, 1, 1, 0, 1, 0, 0, 0); tk();
        ins(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        ng();
        chk("yw_fwd_a", 32'(bus.fwd_a), 32'(FWD_MEM));
        chk("yw_fwd_b", 32'(bus.fwd_b), 32'(FWD_MEM));
        tk();
        ins(1, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0); tk();
        nop();
        ng(); chk("x0_fwd_a", 32'(bus.fwd_a), 32'(FWD_NONE)); tk();

        // csrrs x9 ; unpk rd=x9 as paired source
        do_reset();
        ins(1, 1, 0, 9, 1, 0, 0, 1, 0, 0, 1); tk();
        ins(1, 1, 2, 9, 1, 1, 1, 1, 0, 0, 0);
        ng(); chk("csr_stall", 32'(bus.stall_dec), 1); tk();
        ng(); chk("csr_release", 32'(bus.stall_dec), 0); tk();
        nop();
        ng(); chk("csr_fwd_p", 32'(bus.fwd_p), 32'(FWD_WB)); tk();
        do_reset();
        ins(1, 1, 0, 9, 1, 0, 0, 1, 0, 0, 1); tk();
        ins(1, 1, 2, 9, 1, 1, 0, 1, 0, 0, 0);
        ng(); chk("nop_p_stall", 32'(bus.stall_dec), 0); tk();

        // hazard together with flush
        do_reset();
        ins(1, 0, 0, 5, 1, 0, 0, 1, 1, 0, 0); tk();
        ins(1, 5, 1, 6, 1, 1, 0, 1, 0, 0, 0);
        flush_ex = 1;
        ng(); chk("fl_stall", 32'(bus.stall_dec), 0); tk();
        flush_ex = 0;
        nop();
        ng();
        chk("fl_fwd_a", 32'(bus.fwd_a), 32'(FWD_NONE));
        chk("fl_cnt", 32'(stall_cnt), 0);
        tk();

        // backend freeze during load-use
        do_reset();
        ins(1, 0, 0, 5, 1, 0, 0, 1, 1, 0, 0); tk();
        ins(1, 5, 1, 6, 1, 1, 0, 1, 0, 0, 0);
        be_stall = 1;
        for (int i = 0; i < 3; i++) begin
            ng();
            chk("fz_stall", 32'(bus.stall_dec), 1);
            chk("fz_cnt", 32'(stall_cnt), 0);
            tk();
        end
        be_stall = 0;
        ng(); chk("fz_stall_rel", 32'(bus.stall_dec), 1); tk();
        ng();
        chk("fz_go", 32'(bus.stall_dec), 0);
        chk("fz_cnt1", 32'(stall_cnt), 1);
        tk();
        nop();
        ng(); chk("fz_fwd_a", 32'(bus.fwd_a), 32'(FWD_WB)); tk();

        // reset with three writers in flight
        ins(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0); tk();
        ins(1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0); tk();
        ins(1, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0); tk();
        rst = 1;
        nop();
        tk();
        rst = 0;
        ins(1, 3, 2, 1, 1, 1, 1, 1, 0, 0, 0);
        ng();
        chk("rs_stall", 32'(bus.stall_dec), 0);
        chk("rs_fwd_a", 32'(bus.fwd_a), 32'(FWD_NONE));
        chk("rs_fwd_b", 32'(bus.fwd_b), 32'(FWD_NONE));
        chk("rs_fwd_p", 32'(bus.fwd_p), 32'(FWD_NONE));
        chk("rs_cnt", 32'(stall_cnt), 0);
        tk();

        // saturation: lw x5,0(x5) stalls every other cycle
        do_reset();
        ins(1, 5, 0, 5, 1, 0, 0, 1, 1, 0, 0);
        repeat (40) tk();
        nop();
        ng(); chk("sat_cnt", 32'(stall_cnt), 15); tk();

        // random traffic over a small register window
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int rd;
            rd = int'($urandom_range(0, 7));
            ins(1'($urandom_range(0, 9) != 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rd,
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                (rd != 0) && ($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 7) == 0));
            flush_ex = ($urandom_range(0, 9) == 0);
            be_stall = ($urandom_range(0, 6) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tk();
        end
        rst = 0;
        be_stall = 0;
        flush_ex = 0;
        nop();
        tk();
        tk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
